mdu_control: RTL and testbench

//  Iterative multiply/divide unit with its own op decode, in the Execute stage beside the ALU.
//  - Decodes the spare opcode Alu_op=5'b11010 with Op_ext selecting MUL/MULH/DIV/REM.
//  - Runs a radix-2 shift-add / restoring-divide sequence, one bit per cycle.
//  - Holds stall to the pipeline until the result is ready.
//  - Any other Alu_op is ignored (no start); illegal Op_ext raises err.

---
 rtl/mdu_pkg.sv | 9 +
 rtl/mdu_datapath.sv | 50 +++++
 rtl/mdu_control.sv | 93 +++++++++
 tb/tb_mdu_control.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode, Op_ext function codes and FSM states shared by the multiply/divide unit
package mdu_pkg;
  localparam logic [4:0] MDU_OPC  = 5'b11010;
  localparam logic [1:0] MDU_MUL  = 2'b00;
  localparam logic [1:0] MDU_MULH = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;
  localparam logic [1:0] MDU_REM  = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: shared {hi,lo} shift register for radix-2 shift-add multiply and restoring divide
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture a into lo, b as multiplicand/divisor, clear hi
//   step         advance one iteration
//   div          (MDU_DIV_EN only) select divide step instead of multiply step
//   a, b         operands
//   hi_nx, lo_nx register contents after the current step (product hi/lo or remainder/quotient)
// Macro MDU_DIV_EN adds the restoring-divide step.
module mdu_datapath #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
`ifdef MDU_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nx,
  output logic [WIDTH-1:0] lo_nx
);
  logic [WIDTH-1:0] hi, lo, bq;
  logic [WIDTH:0] sum;
  assign sum = {1'b0, hi} + {1'b0, (lo[0] ? bq : {WIDTH{1'b0}})};
`ifdef MDU_DIV_EN
  // remainder stays below the divisor, so diff[WIDTH] is exactly the borrow
  logic [WIDTH:0] rem_sh, diff;
  assign rem_sh = {hi, lo[WIDTH-1]};
  assign diff = rem_sh - {1'b0, bq};
  assign hi_nx = !div ? sum[WIDTH:1] : diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign lo_nx = !div ? {sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], !diff[WIDTH]};
`else
  assign hi_nx = sum[WIDTH:1];
  assign lo_nx = {sum[0], lo[WIDTH-1:1]};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      bq <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      bq <= b;
    end else if (step) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end
endmodule

// File: rtl/mdu_control.sv
// mdu_control: iterative MUL/MULH/DIV/REM unit with op decode, pipeline stall and done handshake
//   clk, rst_n     clock, asynchronous active-low reset
//   start, flush   valid Execute instr / squash in-flight op
//   Alu_op, Op_ext opcode (11010 selects the unit) and function extension
//   a, b           operands Rs, Rt
//   stall          hold Fetch/Decode/Execute (accept cycle and RUN)
//   done           1-cycle result-valid pulse
//   result         registered result, held until the next done
//   err            1-cycle pulse for an uncompiled op
// Macro MDU_DIV_EN enables DIV/REM; without it Op_ext 1x raises err.
module mdu_control
  import mdu_pkg::*;
#(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [4:0]       Alu_op,
  input  logic [1:0]       Op_ext,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic sel_hi, hit, legal, zdiv, accept, step, last;
  logic [WIDTH-1:0] hi_nx, lo_nx;
`ifdef MDU_DIV_EN
  logic div_q;
  assign legal = 1'b1;
  assign zdiv = Op_ext[1] && b == '0;
`else
  assign legal = Op_ext inside {MDU_MUL, MDU_MULH};
  assign zdiv = 1'b0;
`endif
  assign hit = state == IDLE && start && Alu_op == MDU_OPC && !flush;
  assign accept = hit && legal;
  assign step = state == RUN && !flush;
  assign last = step && cnt == '0;
  always_comb begin
    stall = accept || step;
    done = state == DONE && !flush;
    state_nx = state == IDLE ? (accept ? (zdiv ? DONE : RUN) : IDLE)
             : state == RUN  ? (flush ? IDLE : cnt == '0 ? DONE : RUN)
             : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel_hi <= 1'b0;
`ifdef MDU_DIV_EN
      div_q <= 1'b0;
`endif
      result <= '0;
      err <= 1'b0;
    end else begin
      err <= hit && !legal;
      if (accept) begin
        cnt <= CNT_W'(WIDTH - 1);
        sel_hi <= Op_ext inside {MDU_MULH, MDU_REM};
`ifdef MDU_DIV_EN
        div_q <= Op_ext inside {MDU_DIV, MDU_REM};
`endif
      end else if (step) begin
        cnt <= cnt - 1'b1;
      end
      // zero divisor bypasses RUN: quotient all ones, remainder is the dividend
      if (accept && zdiv) result <= Op_ext == MDU_DIV ? '1 : a;
      else if (last) result <= sel_hi ? hi_nx : lo_nx;
    end
  end
  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .step(step),
`ifdef MDU_DIV_EN
    .div(div_q),
`endif
    .a(a),
    .b(b),
    .hi_nx(hi_nx),
    .lo_nx(lo_nx)
  );
endmodule

// File: tb/tb_mdu_control.sv
// tb_mdu_control: directed vectors against a cycle-count model of the multiply/divide unit
module tb_mdu_control;
  localparam int W = 16;
  localparam logic [4:0] OPC = 5'b11010;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
  logic [4:0] Alu_op = '0;
  logic [1:0] Op_ext = '0;
  logic [W-1:0] a = '0, b = '0;
  logic stall, done, err;
  logic [W-1:0] result;
  int checks = 0, errors = 0;
  int m_run = 0;
  bit m_done = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_res = '0, m_pend = '0;

  mdu_control #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .Alu_op(Alu_op), .Op_ext(Op_ext), .a(a), .b(b),
    .stall(stall), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] golden(input logic [1:0] e, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (e)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
      2'b10: return y == 0 ? {W{1'b1}} : x / y;
      default: return y == 0 ? x : x % y;
    endcase
  endfunction

  // model: an accepted op occupies W run cycles (none for a zero divisor), then one done cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_res = '0;
    end else begin
      m_err = 1'b0;
      if (m_done) m_done = 1'b0;
      else if (m_run > 0) begin
        if (flush) m_run = 0;
        else begin
          m_run--;
          if (m_run == 0) begin
            m_done = 1'b1;
            m_res = m_pend;
          end
        end
      end else if (start && Alu_op == OPC && !flush) begin
        if (!DIV_EN && Op_ext[1]) m_err = 1'b1;
        else if (Op_ext[1] && b == 0) begin
          m_done = 1'b1;
          m_res = golden(Op_ext, a, b);
        end else begin
          m_pend = golden(Op_ext, a, b);
          m_run = W;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit idle, acc;
    idle = m_run == 0 && !m_done;
    acc = idle && start && Alu_op == OPC && !flush && (DIV_EN || !Op_ext[1]);
    cmp("stall", stall, acc || (m_run > 0 && !flush));
    cmp("done", done, m_done && !flush);
    cmp("err", err, m_err);
    cmp("result", result, m_res);
  end

  task automatic issue(input logic [4:0] op, input logic [1:0] e, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1 start = 1'b1; Alu_op = op; Op_ext = e; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; Alu_op = '0;
  endtask

  task automatic wait_done(input logic [W-1:0] lit, input int lat, input string nm);
    int k;
    k = 1;
    @(negedge clk);
    while (!done && k < 40) begin
      k++;
      @(negedge clk);
    end
    cmp({nm, "_latency"}, k, lat);
    cmp({nm, "_result"}, result, lit);
  endtask

  task automatic run_op(input logic [1:0] e, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] lit, input int lat, input string nm);
    issue(OPC, e, x, y);
    wait_done(lit, lat, nm);
  endtask

  initial begin
    int dcnt;
    #1 rst_n = 1'b0;
    @(negedge clk);
    cmp("rst_stall", stall, 0);
    cmp("rst_done", done, 0);
    cmp("rst_err", err, 0);
    cmp("rst_result", result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(2'b00, 16'h0003, 16'h0005, 16'h000F, 17, "mul_3x5");
    run_op(2'b00, 16'h0000, 16'h1234, 16'h0000, 17, "mul_a0");
    run_op(2'b01, 16'h1234, 16'h0000, 16'h0000, 17, "mulh_b0");
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17, "mulh_ffff");
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 17, "mul_ffff");
`ifdef MDU_DIV_EN
    run_op(2'b10, 16'h0064, 16'h0007, 16'h000E, 17, "div_100_7");
    run_op(2'b11, 16'h0064, 16'h0007, 16'h0002, 17, "rem_100_7");
    run_op(2'b10, 16'h1234, 16'h0000, 16'hFFFF, 1, "div_by_0");
    run_op(2'b11, 16'h1234, 16'h0000, 16'h1234, 1, "rem_by_0");
    run_op(2'b10, 16'h0007, 16'h0009, 16'h0000, 17, "div_small");
    run_op(2'b11, 16'h0007, 16'h0009, 16'h0007, 17, "rem_small");
    run_op(2'b10, 16'hFFFF, 16'h0001, 16'hFFFF, 17, "div_by_1");
`else
    issue(OPC, 2'b10, 16'h0064, 16'h0007);
    @(negedge clk);
    cmp("div_err_pulse", err, 1);
    cmp("div_err_stall", stall, 0);
    @(negedge clk);
    cmp("div_err_once", err, 0);
    cmp("div_err_result", result, 16'h0001);
    issue(OPC, 2'b11, 16'h0064, 16'h0000);
    @(negedge clk);
    cmp("rem_err_pulse", err, 1);
    @(negedge clk);
    cmp("rem_err_once", err, 0);
`endif
    issue(OPC, 2'b00, 16'h0007, 16'h0009);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    cmp("flush_stall", stall, 0);
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    cmp("flush_no_done", dcnt, 0);
    run_op(2'b00, 16'h0012, 16'h0034, 16'h03A8, 17, "mul_after_flush");
    @(posedge clk);
    #1 start = 1'b1; Alu_op = OPC; Op_ext = 2'b00; a = 16'h0005; b = 16'h0005; flush = 1'b1;
    @(negedge clk);
    cmp("flush_accept_stall", stall, 0);
    @(posedge clk);
    #1 start = 1'b0; Alu_op = '0; flush = 1'b0;
    @(negedge clk);
    cmp("flush_accept_idle", stall, 0);
    issue(5'b11011, 2'b00, 16'h0003, 16'h0003);
    @(negedge clk);
    cmp("other_opcode_stall", stall, 0);
    issue(OPC, 2'b00, 16'h0101, 16'h0002);
    @(posedge clk);
    #1 start = 1'b1; Alu_op = OPC; Op_ext = 2'b01; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0; Alu_op = '0;
    wait_done(16'h0202, 15, "busy_ignore");
    issue(OPC, 2'b01, 16'hFFFF, 16'hFFFF);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_stall", stall, 0);
    cmp("async_rst_done", done, 0);
    cmp("async_rst_err", err, 0);
    cmp("async_rst_result", result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(2'b00, 16'h00FF, 16'h0101, 16'hFFFF, 17, "mul_after_rst");
    run_op(2'b01, 16'h00FF, 16'h0101, 16'h0000, 17, "mulh_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
